// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage
//                (fetch FSM state encoding, NOP bubble, default reset PC).
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch controller state: issue, wait for response, hold a stalled
    // response, or discard a wrong-path response.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0 -- injected into Decode on bubbles and flushes
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Instruction-memory request/response bus between the fetch
//                stage (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;

    logic        ImemReqF;
    logic [31:0] ImemAddrF;
    logic        ImemReady;
    logic        ImemRValid;
    logic [31:0] ImemRData;

    modport master (
        output ImemReqF,
        output ImemAddrF,
        input  ImemReady,
        input  ImemRValid,
        input  ImemRData
    );

    modport slave (
        input  ImemReqF,
        input  ImemAddrF,
        output ImemReady,
        output ImemRValid,
        output ImemRData
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Priority flush > stall > load >
//                bubble; flush and bubble insert a NOP and keep the PC fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid
);
    import fetch_pkg::*;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    // Next IF/ID contents; PC fields only change on a real load
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr_d    = instr_in;
                pc_d       = pc_in;
                pc_plus4_d = pc_in + 32'd4;
                valid_d    = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // Register with synchronous active-low reset to a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32I instruction-fetch stage. Owns the PC, keeps at most one
//                memory request outstanding, squashes wrong-path responses on
//                redirect and buffers one response while Decode is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           StallF,
    input  logic           StallD,
    input  logic           FlushD,
    input  logic           PCSrcE,
    input  logic [31:0]    PCTargetE,
    fetch_if.master        imem,
    output logic [31:0]    InstrD,
    output logic [31:0]    PCD,
    output logic [31:0]    PCPlus4D,
    output logic           ValidD
);
    import fetch_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic         hold_valid_q, hold_valid_d;

    logic         accept;
    logic         load_wait;
    logic         load_hold;
    logic         capture;
    logic         load;
    logic [31:0]  load_instr;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pcf_q        <= RESET_PC;
            req_pc_q     <= 32'd0;
            hold_instr_q <= 32'd0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            req_pc_q     <= req_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Next state; a redirect turns any in-flight request into a discard
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (accept) state_d = PCSrcE ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (PCSrcE)               state_d = imem.ImemRValid ? ST_REQ : ST_DROP;
                else if (imem.ImemRValid) state_d = StallD ? ST_HOLD : ST_REQ;
            end
            ST_HOLD: begin
                if (PCSrcE || !StallD) state_d = ST_REQ;
            end
            ST_DROP: begin
                if (imem.ImemRValid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    // Bus request and IF/ID load controls
    always_comb begin
        imem.ImemReqF  = rst_n && (state_q == ST_REQ) && !StallF;
        imem.ImemAddrF = pcf_q;
        accept         = imem.ImemReqF && imem.ImemReady;
        load_wait      = (state_q == ST_WAIT) && imem.ImemRValid && !PCSrcE && !StallD;
        capture        = (state_q == ST_WAIT) && imem.ImemRValid && !PCSrcE && StallD;
        load_hold      = (state_q == ST_HOLD) && hold_valid_q && !PCSrcE && !StallD;
        load           = load_wait || load_hold;
        load_instr     = load_hold ? hold_instr_q : imem.ImemRData;
    end

    // PC, request PC and hold buffer; redirect overrides the sequential PC
    always_comb begin
        pcf_d        = pcf_q;
        req_pc_d     = req_pc_q;
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;
        if (accept) begin
            req_pc_d = pcf_q;
            pcf_d    = pcf_q + 32'd4;
        end
        if (capture) begin
            hold_instr_d = imem.ImemRData;
            hold_valid_d = 1'b1;
        end
        if (load_hold) hold_valid_d = 1'b0;
        if (PCSrcE) begin
            pcf_d        = PCTargetE;
            hold_valid_d = 1'b0;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (FlushD),
        .stall    (StallD),
        .load     (load),
        .instr_in (load_instr),
        .pc_in    (req_pc_q),
        .instr    (InstrD),
        .pc       (PCD),
        .pc_plus4 (PCPlus4D),
        .valid    (ValidD)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed scenarios plus
//                randomized hazards, redirects and memory timing against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [31:0] InstrD_b, PCD_b, PCPlus4D_b;
    logic        ValidD_b;

    fetch_if ifa ();
    fetch_if ifb ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(ifa),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
        .PCSrcE(1'b0), .PCTargetE(32'h0), .imem(ifb),
        .InstrD(InstrD_b), .PCD(PCD_b), .PCPlus4D(PCPlus4D_b), .ValidD(ValidD_b)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model (transaction level) -----------------
    typedef struct { logic [31:0] pc; bit kill; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } held_t;
    pend_t       pend_q[$];
    held_t       held_q[$];
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    bit          m_valid;
    bit          seen_bad;

    // ---------------- memory environment ----------------------------------
    bit          mem_busy, mem_acc, acc_b;
    logic [31:0] mem_addr, mem_acc_addr;
    int          mem_delay, mem_lat;
    bit          lat_rand, rdy_rand, spur_en;
    bit          ovr_en;
    logic [31:0] ovr_data;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   word = 32'h0050_0093;
            32'h4:   word = 32'h0010_0113;
            32'h8:   word = 32'h0020_8193;
            default: word = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return rst_n && !StallF && pend_q.size() == 0 && held_q.size() == 0;
    endfunction

    task automatic model_reset(input logic [31:0] rpc);
        pend_q.delete();
        held_q.delete();
        m_pc = rpc; m_instr = NOP; m_valid = 0; m_pcd = 0; m_pc4 = 0;
    endtask

    // Advance the model by one clock using the inputs presented this cycle
    task automatic model_step();
        bit          accept, resp, do_load;
        logic [31:0] ld_instr, ld_pc;
        pend_t       p;
        if (!rst_n) begin
            model_reset(32'h0);
            return;
        end
        accept   = exp_req() && ifa.ImemReady;
        resp     = pend_q.size() != 0 && ifa.ImemRValid;
        do_load  = 0;
        ld_instr = 0;
        ld_pc    = 0;
        if (held_q.size() != 0) begin
            if (PCSrcE) held_q.delete();
            else if (!StallD) begin
                do_load = 1; ld_instr = held_q[0].instr; ld_pc = held_q[0].pc;
                held_q.delete();
            end
        end
        if (resp) begin
            p = pend_q.pop_front();
            if (!p.kill && !PCSrcE) begin
                if (!StallD) begin do_load = 1; ld_instr = ifa.ImemRData; ld_pc = p.pc; end
                else held_q.push_back('{instr: ifa.ImemRData, pc: p.pc});
            end
        end else if (PCSrcE && pend_q.size() != 0) begin
            pend_q[0].kill = 1;
        end
        if (accept) pend_q.push_back('{pc: m_pc, kill: PCSrcE});
        if (PCSrcE)      m_pc = PCTargetE;
        else if (accept) m_pc = m_pc + 32'd4;
        if (FlushD) begin
            m_instr = NOP; m_valid = 0;
        end else if (!StallD) begin
            if (do_load) begin
                m_instr = ld_instr; m_pcd = ld_pc; m_pc4 = ld_pc + 32'd4; m_valid = 1;
            end else begin
                m_instr = NOP; m_valid = 0;
            end
        end
    endtask

    // One clock: compare at negedge, step model, then drive memory after edge
    task automatic step();
        @(negedge clk);
        chk("ImemReqF",  {31'd0, ifa.ImemReqF}, {31'd0, exp_req()});
        chk("ImemAddrF", ifa.ImemAddrF, m_pc);
        chk("InstrD",    InstrD, m_instr);
        chk("ValidD",    {31'd0, ValidD}, {31'd0, m_valid});
        chk("PCD",       PCD, m_pcd);
        chk("PCPlus4D",  PCPlus4D, m_pc4);
        if (InstrD == 32'hDEAD_BEEF) seen_bad = 1;
        model_step();
        mem_acc      = ifa.ImemReqF && ifa.ImemReady;
        mem_acc_addr = ifa.ImemAddrF;
        acc_b        = ifb.ImemReqF;
        @(posedge clk);
        #1;
        ifa.ImemRValid = 0;
        ifa.ImemRData  = $urandom;
        if (!rst_n) begin
            mem_busy       = 0;
            ifb.ImemRValid = 0;
        end else begin
            if (mem_acc) begin
                mem_busy  = 1;
                mem_addr  = mem_acc_addr;
                mem_delay = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (mem_busy) begin
                if (mem_delay == 0) begin
                    ifa.ImemRValid = 1;
                    ifa.ImemRData  = ovr_en ? ovr_data : word(mem_addr);
                    ovr_en         = 0;
                    mem_busy       = 0;
                end else begin
                    mem_delay--;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                ifa.ImemRValid = 1;
            end
            ifb.ImemRValid = acc_b;
        end
        ifb.ImemRData = 32'h0040_0093;
        ifa.ImemReady = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        rst_n = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        ifa.ImemReady = 1; ifa.ImemRValid = 0; ifa.ImemRData = 0;
        ifb.ImemReady = 1; ifb.ImemRValid = 0; ifb.ImemRData = 0;
        mem_busy = 0; mem_lat = 0; lat_rand = 0; rdy_rand = 0; spur_en = 0;
        ovr_en = 0; ovr_data = 0; seen_bad = 0; mem_delay = 0; mem_addr = 0;
        model_reset(32'h0);
        repeat (3) @(posedge clk);
        #1;
        step(); step();
        chk("rst_InstrD",   InstrD, NOP);
        chk("rst_ValidD",   {31'd0, ValidD}, 32'd0);
        chk("rst_PCD",      PCD, 32'd0);
        chk("rst_PCPlus4D", PCPlus4D, 32'd0);
        chk("rst_ImemReqF", {31'd0, ifa.ImemReqF}, 32'd0);

        // first two instructions, memory always ready with 1-cycle latency
        rst_n = 1;
        step(); step();
        chk("first_InstrD",   InstrD, 32'h0050_0093);
        chk("first_PCD",      PCD, 32'h0);
        chk("first_PCPlus4D", PCPlus4D, 32'h4);
        chk("first_ValidD",   {31'd0, ValidD}, 32'd1);
        chk("model_first",    m_instr, 32'h0050_0093);
        chk("wrap_addr2",     ifb.ImemAddrF, 32'h0);
        chk("wrap_req2",      {31'd0, ifb.ImemReqF}, 32'd1);
        chk("wrap_PCD",       PCD_b, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4D",  PCPlus4D_b, 32'h0);
        chk("wrap_ValidD",    {31'd0, ValidD_b}, 32'd1);
        step();
        chk("bubble_ValidD",  {31'd0, ValidD}, 32'd0);
        step();
        chk("second_InstrD",  InstrD, 32'h0010_0113);
        chk("second_PCD",     PCD, 32'h4);

        // StallD across a response: held, then delivered exactly once
        StallD = 1;
        step(); step(); step();
        chk("stall_InstrD",   InstrD, 32'h0010_0113);
        chk("stall_ValidD",   {31'd0, ValidD}, 32'd1);
        StallD = 0;
        step();
        chk("held_InstrD",    InstrD, 32'h0020_8193);
        chk("held_PCD",       PCD, 32'h8);
        chk("model_held",     m_pcd, 32'h8);
        mem_lat = 2; ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
        step();
        chk("nodup_ValidD",   {31'd0, ValidD}, 32'd0);

        // redirect while waiting; late wrong-path response must be dropped
        PCSrcE = 1; PCTargetE = 32'h100;
        step();
        PCSrcE = 0;
        step();
        mem_lat = 0;
        step();
        chk("redir_req",      {31'd0, ifa.ImemReqF}, 32'd1);
        chk("redir_addr",     ifa.ImemAddrF, 32'h100);
        step();

        // redirect in the same cycle as the response
        PCSrcE = 1; PCTargetE = 32'h200;
        step();
        PCSrcE = 0;
        chk("same_req",       {31'd0, ifa.ImemReqF}, 32'd1);
        chk("same_addr",      ifa.ImemAddrF, 32'h200);
        chk("same_ValidD",    {31'd0, ValidD}, 32'd0);
        step(); step();
        chk("pre_flush_PCD",  PCD, 32'h200);

        // flush and stall together
        FlushD = 1; StallD = 1;
        step();
        chk("flush_InstrD",   InstrD, 32'h0000_0013);
        chk("flush_ValidD",   {31'd0, ValidD}, 32'd0);
        chk("flush_PCD",      PCD, 32'h200);
        FlushD = 0; StallD = 0;
        chk("no_wrong_path",  {31'd0, seen_bad}, 32'd0);

        // randomized traffic with one mid-run reset
        lat_rand = 1; rdy_rand = 1; spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_n  = !(i == 1500 || i == 1501);
            StallF = ($urandom_range(0, 3) == 0);
            StallD = ($urandom_range(0, 3) == 0);
            FlushD = ($urandom_range(0, 9) == 0);
            PCSrcE = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
            PCTargetE = tgt;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
